// File: rtl/rx_udp_pkg.sv
// Shared encodings and UDP header layout for the receive-side UDP demultiplexer.
package rx_udp_pkg;

    typedef enum logic [1:0] {
        HDR     = 2'd0,
        PAYLOAD = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    localparam int UDP_HDR_LEN = 8;

    // Byte offsets of each 16-bit header field, MSB byte first
    localparam int SRC_OFS  = 0;
    localparam int DST_OFS  = 2;
    localparam int LEN_OFS  = 4;
    localparam int CSUM_OFS = 6;

endpackage

// File: rtl/rx_udp_demux_if.sv
// Byte stream from the IP layer plus the parsed UDP header/payload bus.
interface rx_udp_demux_if #(
    parameter int OCT    = 8,
    parameter int N_PORT = 4
);
    logic                rx_data_v;
    logic [OCT-1:0]      rx_data;
    logic [2*OCT-1:0]    rx_src_port;
    logic [2*OCT-1:0]    rx_dst_port;
    logic [2*OCT-1:0]    rx_pay_len;
    logic                rx_hdr_v;
    logic [N_PORT-1:0]   rx_hit;
    logic                rx_udp_data_v;
    logic [OCT-1:0]      rx_udp_data;
    logic                rx_udp_last;
    logic                rx_udp_err;
    logic                rx_udp_drop;

    modport master (
        output rx_data_v, rx_data,
        input  rx_src_port, rx_dst_port, rx_pay_len, rx_hdr_v, rx_hit,
               rx_udp_data_v, rx_udp_data, rx_udp_last, rx_udp_err, rx_udp_drop
    );

    modport slave (
        input  rx_data_v, rx_data,
        output rx_src_port, rx_dst_port, rx_pay_len, rx_hdr_v, rx_hit,
               rx_udp_data_v, rx_udp_data, rx_udp_last, rx_udp_err, rx_udp_drop
    );
endinterface

// File: rtl/rx_udp_port_match.sv
// Compares a destination port against the listening table; lowest enabled index wins.
module rx_udp_port_match #(
    parameter int OCT    = 8,
    parameter int N_PORT = 4
) (
    input  logic [N_PORT*OCT*2-1:0] port_tbl,
    input  logic [N_PORT-1:0]       port_en,
    input  logic [2*OCT-1:0]        dst,
    output logic [N_PORT-1:0]       hit
);

    // Scan from the top down so the lowest matching index overwrites the rest
    always_comb begin
        hit = '0;
        for (int i = N_PORT - 1; i >= 0; i--) begin
            if (port_en[i] && (port_tbl[i*2*OCT +: 2*OCT] == dst)) begin
                hit    = '0;
                hit[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rx_udp_demux.sv
// UDP header parser and port demultiplexer: strips the 8-byte header, matches the
// destination port against a listening table and forwards the payload one cycle later.
module rx_udp_demux
    import rx_udp_pkg::*;
#(
    parameter int OCT    = 8,
    parameter int N_PORT = 4
) (
    input  logic                    RX_CLK,
    input  logic                    rst,
    input  logic [N_PORT*OCT*2-1:0] port_tbl,
    input  logic [N_PORT-1:0]       port_en,
    rx_udp_demux_if.slave           bus
);

    localparam int FW = 2 * OCT;
    localparam logic [FW-1:0] HDR_LEN_W = FW'(UDP_HDR_LEN);

    state_t            state, state_nxt;
    logic [15:0]       cnt, cnt_nxt;
    logic              armed, armed_nxt;
    logic [FW-1:0]     src_sr, dst_sr, len_sr, csum_sr;
    logic [FW-1:0]     src_sr_nxt, dst_sr_nxt, len_sr_nxt, csum_sr_nxt;
    logic [FW-1:0]     src_q, dst_q, pay_len_q;
    logic [FW-1:0]     src_nxt, dst_nxt, pay_len_nxt;
    logic [N_PORT-1:0] hit_q, hit_nxt, match_hit;
    logic [OCT-1:0]    data_q, data_nxt;
    logic              hdr_v_q, hdr_v_nxt, data_v_q, data_v_nxt, last_q, last_nxt;
    logic              err_q, err_nxt, drop_q, drop_nxt;
    logic [15:0]       pay_len_m1;

    rx_udp_port_match #(.OCT(OCT), .N_PORT(N_PORT)) u_match (
        .port_tbl (port_tbl),
        .port_en  (port_en),
        .dst      (dst_sr),
        .hit      (match_hit)
    );

    assign pay_len_m1 = 16'(pay_len_q) - 16'd1;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        // After reset, wait for an idle cycle so a frame in flight is never half-parsed
        armed_nxt   = armed | ~bus.rx_data_v;
        src_sr_nxt  = src_sr;
        dst_sr_nxt  = dst_sr;
        len_sr_nxt  = len_sr;
        csum_sr_nxt = csum_sr;
        src_nxt     = src_q;
        dst_nxt     = dst_q;
        pay_len_nxt = pay_len_q;
        hit_nxt     = hit_q;
        data_nxt    = data_q;
        hdr_v_nxt   = 1'b0;
        data_v_nxt  = 1'b0;
        last_nxt    = 1'b0;
        err_nxt     = 1'b0;
        drop_nxt    = 1'b0;

        if (!bus.rx_data_v) begin
            state_nxt = HDR;
            cnt_nxt   = '0;
            err_nxt   = (state == PAYLOAD);
        end else if (armed) begin
            unique case (state)
                HDR: begin
                    cnt_nxt = cnt + 16'd1;
                    if (cnt < 16'(DST_OFS))       src_sr_nxt  = {src_sr[OCT-1:0], bus.rx_data};
                    else if (cnt < 16'(LEN_OFS))  dst_sr_nxt  = {dst_sr[OCT-1:0], bus.rx_data};
                    else if (cnt < 16'(CSUM_OFS)) len_sr_nxt  = {len_sr[OCT-1:0], bus.rx_data};
                    else                          csum_sr_nxt = {csum_sr[OCT-1:0], bus.rx_data};

                    if (cnt == 16'(UDP_HDR_LEN - 1)) begin
                        src_nxt   = src_sr;
                        dst_nxt   = dst_sr;
                        hdr_v_nxt = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = DRAIN;
                        if (len_sr < HDR_LEN_W) begin
                            err_nxt     = 1'b1;
                            hit_nxt     = '0;
                            pay_len_nxt = '0;
                        end else begin
                            pay_len_nxt = len_sr - HDR_LEN_W;
                            hit_nxt     = match_hit;
                            if (match_hit == '0)          drop_nxt  = 1'b1;
                            else if (len_sr != HDR_LEN_W) state_nxt = PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    data_nxt   = bus.rx_data;
                    data_v_nxt = 1'b1;
                    cnt_nxt    = cnt + 16'd1;
                    if (cnt == pay_len_m1) begin
                        last_nxt  = 1'b1;
                        state_nxt = DRAIN;
                    end
                end
                DRAIN: ;
                default: state_nxt = HDR;
            endcase
        end
    end

    always_ff @(posedge RX_CLK or posedge rst) begin
        if (rst) begin
            state     <= HDR;
            cnt       <= '0;
            armed     <= 1'b0;
            src_sr    <= '0;
            dst_sr    <= '0;
            len_sr    <= '0;
            csum_sr   <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            pay_len_q <= '0;
            hit_q     <= '0;
            data_q    <= '0;
            hdr_v_q   <= 1'b0;
            data_v_q  <= 1'b0;
            last_q    <= 1'b0;
            err_q     <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            armed     <= armed_nxt;
            src_sr    <= src_sr_nxt;
            dst_sr    <= dst_sr_nxt;
            len_sr    <= len_sr_nxt;
            csum_sr   <= csum_sr_nxt;
            src_q     <= src_nxt;
            dst_q     <= dst_nxt;
            pay_len_q <= pay_len_nxt;
            hit_q     <= hit_nxt;
            data_q    <= data_nxt;
            hdr_v_q   <= hdr_v_nxt;
            data_v_q  <= data_v_nxt;
            last_q    <= last_nxt;
            err_q     <= err_nxt;
            drop_q    <= drop_nxt;
        end
    end

    assign bus.rx_src_port   = src_q;
    assign bus.rx_dst_port   = dst_q;
    assign bus.rx_pay_len    = pay_len_q;
    assign bus.rx_hdr_v      = hdr_v_q;
    assign bus.rx_hit        = hit_q;
    assign bus.rx_udp_data_v = data_v_q;
    assign bus.rx_udp_data   = data_q;
    assign bus.rx_udp_last   = last_q;
    assign bus.rx_udp_err    = err_q;
    assign bus.rx_udp_drop   = drop_q;

endmodule

// File: tb/tb_rx_udp_demux.sv
// Directed frames against rx_udp_demux with hand-computed expected beats and pulses.
module tb_rx_udp_demux;

    logic        RX_CLK = 1'b0;
    logic        rst;
    logic [63:0] port_tbl;
    logic [3:0]  port_en;

    rx_udp_demux_if #(.OCT(8), .N_PORT(4)) bus ();

    rx_udp_demux #(.OCT(8), .N_PORT(4)) dut (
        .RX_CLK   (RX_CLK),
        .rst      (rst),
        .port_tbl (port_tbl),
        .port_en  (port_en),
        .bus      (bus.slave)
    );

    always #5 RX_CLK = ~RX_CLK;

    int vec_cnt = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [7:0] frame_q[$];
    logic [7:0] beats[$];
    logic [7:0] exp_q[$];
    int hdr_cnt, err_cnt, drop_cnt, last_cnt, last_idx, stray_last;
    int first_beat_cyc, err_cyc, pay_cyc, fall_cyc;

    always @(posedge RX_CLK) cyc <= cyc + 1;

    always @(negedge RX_CLK) begin
        if (!rst) begin
            if (bus.rx_udp_data_v) begin
                if (first_beat_cyc < 0) first_beat_cyc = cyc;
                beats.push_back(bus.rx_udp_data);
                if (bus.rx_udp_last) begin
                    last_cnt++;
                    last_idx = beats.size() - 1;
                end
            end else if (bus.rx_udp_last) begin
                stray_last++;
            end
            if (bus.rx_hdr_v) hdr_cnt++;
            if (bus.rx_udp_err) begin
                err_cnt++;
                err_cyc = cyc;
            end
            if (bus.rx_udp_drop) drop_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        beats.delete();
        hdr_cnt = 0; err_cnt = 0; drop_cnt = 0; last_cnt = 0;
        last_idx = -1; stray_last = 0; first_beat_cyc = -1; err_cyc = -1;
        pay_cyc = -1; fall_cyc = -1;
    endtask

    task automatic build(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len);
        frame_q.delete();
        frame_q.push_back(src[15:8]); frame_q.push_back(src[7:0]);
        frame_q.push_back(dst[15:8]); frame_q.push_back(dst[7:0]);
        frame_q.push_back(len[15:8]); frame_q.push_back(len[7:0]);
        frame_q.push_back(8'hBE);     frame_q.push_back(8'hEF);
    endtask

    task automatic drive_byte(input logic [7:0] b);
        @(posedge RX_CLK); #1;
        bus.rx_data_v = 1'b1;
        bus.rx_data   = b;
    endtask

    // Whole frame followed by exactly one idle cycle
    task automatic drive_frame();
        for (int i = 0; i < frame_q.size(); i++) begin
            drive_byte(frame_q[i]);
            if (i == 8) pay_cyc = cyc;
        end
        @(posedge RX_CLK); #1;
        bus.rx_data_v = 1'b0;
        bus.rx_data   = 8'h00;
        fall_cyc = cyc;
    endtask

    task automatic settle();
        repeat (3) @(posedge RX_CLK);
        #1;
    endtask

    task automatic check_beats(input string t);
        chk({t, " nbeats"}, beats.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < beats.size(); i++)
            chk({t, " beat"}, {24'h0, beats[i]}, {24'h0, exp_q[i]});
        chk({t, " stray_last"}, stray_last, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.rx_data_v = 1'b0;
        bus.rx_data   = 8'h00;
        port_tbl = {16'h4444, 16'h3333, 16'h1234, 16'h1234};
        port_en  = 4'b0010;
        clear_mon();

        @(negedge RX_CLK);
        chk("rst hit", bus.rx_hit, 0);
        chk("rst ports", {bus.rx_src_port, bus.rx_dst_port}, 0);
        chk("rst paylen", bus.rx_pay_len, 0);
        chk("rst pulses", {bus.rx_hdr_v, bus.rx_udp_data_v, bus.rx_udp_last,
                           bus.rx_udp_err, bus.rx_udp_drop, bus.rx_udp_data}, 0);
        @(posedge RX_CLK); #1;
        rst = 1'b0;
        repeat (2) @(posedge RX_CLK);
        #1;

        // Basic hit on channel 1; channel 0 holds the same port but is disabled
        clear_mon();
        build(16'h5555, 16'h1234, 16'h000C);
        frame_q.push_back(8'hAA); frame_q.push_back(8'hBB);
        frame_q.push_back(8'hCC); frame_q.push_back(8'hDD);
        drive_frame();
        settle();
        exp_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        check_beats("t1");
        chk("t1 hit", bus.rx_hit, 4'b0010);
        chk("t1 last_cnt", last_cnt, 1);
        chk("t1 last_idx", last_idx, 3);
        chk("t1 err", err_cnt, 0);
        chk("t1 drop", drop_cnt, 0);
        chk("t1 hdr", hdr_cnt, 1);
        chk("t1 src", bus.rx_src_port, 16'h5555);
        chk("t1 dst", bus.rx_dst_port, 16'h1234);
        chk("t1 paylen", bus.rx_pay_len, 16'h0004);
        chk("t1 latency", first_beat_cyc - pay_cyc, 1);

        // No listener for the destination
        clear_mon();
        build(16'h5555, 16'h9999, 16'h000C);
        frame_q.push_back(8'h01); frame_q.push_back(8'h02);
        frame_q.push_back(8'h03); frame_q.push_back(8'h04);
        drive_frame();
        settle();
        exp_q = {};
        check_beats("t2");
        chk("t2 drop", drop_cnt, 1);
        chk("t2 hit", bus.rx_hit, 0);
        chk("t2 err", err_cnt, 0);

        // Truncated payload: length promises 2 bytes, only 1 arrives
        clear_mon();
        build(16'h5555, 16'h1234, 16'h000A);
        frame_q.push_back(8'h5A);
        drive_frame();
        settle();
        exp_q = '{8'h5A};
        check_beats("t3");
        chk("t3 last_cnt", last_cnt, 0);
        chk("t3 err", err_cnt, 1);
        chk("t3 err_delay", err_cyc - fall_cyc, 1);

        // Pad bytes after the payload, two enabled channels share the port
        port_tbl = {16'h4444, 16'h2222, 16'h1234, 16'h2222};
        port_en  = 4'b0111;
        clear_mon();
        build(16'h0A0B, 16'h2222, 16'h000C);
        frame_q.push_back(8'h11); frame_q.push_back(8'h22);
        frame_q.push_back(8'h33); frame_q.push_back(8'h44);
        for (int i = 0; i < 6; i++) frame_q.push_back(8'hF0 + 8'(i));
        drive_frame();
        settle();
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        check_beats("t4");
        chk("t4 hit", bus.rx_hit, 4'b0001);
        chk("t4 last_idx", last_idx, 3);
        chk("t4 err", err_cnt, 0);

        // Length below header size
        clear_mon();
        build(16'h0A0B, 16'h1234, 16'h0005);
        frame_q.push_back(8'h77); frame_q.push_back(8'h78);
        drive_frame();
        settle();
        exp_q = {};
        check_beats("t5");
        chk("t5 err", err_cnt, 1);
        chk("t5 hit", bus.rx_hit, 0);
        chk("t5 drop", drop_cnt, 0);

        // Header-only datagram
        clear_mon();
        build(16'h0A0B, 16'h1234, 16'h0008);
        frame_q.push_back(8'h66); frame_q.push_back(8'h67);
        drive_frame();
        settle();
        exp_q = {};
        check_beats("t6");
        chk("t6 hdr", hdr_cnt, 1);
        chk("t6 hit", bus.rx_hit, 4'b0010);
        chk("t6 paylen", bus.rx_pay_len, 0);
        chk("t6 err_drop", {err_cnt[15:0], drop_cnt[15:0]}, 0);

        // Back-to-back frames, one idle cycle apart
        clear_mon();
        build(16'h0001, 16'h1234, 16'h000A);
        frame_q.push_back(8'h01); frame_q.push_back(8'h02);
        drive_frame();
        build(16'h0002, 16'h2222, 16'h000B);
        frame_q.push_back(8'h03); frame_q.push_back(8'h04); frame_q.push_back(8'h05);
        drive_frame();
        settle();
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        check_beats("t7");
        chk("t7 hdr", hdr_cnt, 2);
        chk("t7 last_cnt", last_cnt, 2);
        chk("t7 hit", bus.rx_hit, 4'b0001);
        chk("t7 src", bus.rx_src_port, 16'h0002);

        // Reset in the middle of a payload; the stream keeps going after release
        build(16'h0101, 16'h1234, 16'h000C);
        frame_q.push_back(8'h81); frame_q.push_back(8'h82);
        for (int i = 0; i < 10; i++) drive_byte(frame_q[i]);
        @(posedge RX_CLK); #1;
        rst = 1'b1;
        clear_mon();
        @(negedge RX_CLK);
        chk("t8 rst hit", bus.rx_hit, 0);
        chk("t8 rst data", {bus.rx_udp_data_v, bus.rx_udp_data}, 0);
        chk("t8 rst ports", {bus.rx_src_port, bus.rx_dst_port, bus.rx_pay_len}, 0);
        chk("t8 rst pulses", {bus.rx_hdr_v, bus.rx_udp_last, bus.rx_udp_err, bus.rx_udp_drop}, 0);
        @(posedge RX_CLK); #1;
        rst = 1'b0;
        build(16'h7777, 16'h1234, 16'h000C);
        for (int i = 0; i < 4; i++) frame_q.push_back(8'hEE);
        for (int i = 0; i < frame_q.size(); i++) drive_byte(frame_q[i]);
        @(posedge RX_CLK); #1;
        bus.rx_data_v = 1'b0;
        build(16'h0202, 16'h1234, 16'h000C);
        frame_q.push_back(8'h91); frame_q.push_back(8'h92);
        frame_q.push_back(8'h93); frame_q.push_back(8'h94);
        drive_frame();
        settle();
        exp_q = '{8'h91, 8'h92, 8'h93, 8'h94};
        check_beats("t8");
        chk("t8 hdr", hdr_cnt, 1);
        chk("t8 err", err_cnt, 0);
        chk("t8 drop", drop_cnt, 0);
        chk("t8 last_cnt", last_cnt, 1);
        chk("t8 src", bus.rx_src_port, 16'h0202);
        chk("t8 hit", bus.rx_hit, 4'b0010);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule

// File: doc/rx_udp_demux.md
RX_UDP_DEMUX -- requirements
Module: rx_udp_demux

Interface
REQ-001 Parameter OCT, default 8, data byte width in bits.
REQ-002 Parameter N_PORT, default 4, number of listening UDP channels.
REQ-003 RX_CLK  input  1  receive clock; all logic SHALL be clocked on the posedge of RX_CLK.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 port_tbl  input  N_PORT*OCT*2  listening port table; channel i occupies bits [i*16+15 : i*16].
REQ-006 port_en  input  N_PORT  per-channel enable; a disabled entry never matches.
REQ-007 rx_data_v  input  1  frame-valid from the IP layer; high for the whole UDP segment, low between frames.
REQ-008 rx_data  input  OCT  UDP byte stream, header first, MSB-first fields.
REQ-009 rx_src_port / rx_dst_port  output  OCT*2 each  captured header ports.
REQ-010 rx_pay_len  output  OCT*2  payload length, computed as the header length field minus 8.
REQ-011 rx_hdr_v  output  1  one-cycle pulse when the header is complete and rx_hit is valid.
REQ-012 rx_hit  output  N_PORT  one-hot matched channel, held until the next frame header completes.
REQ-013 rx_udp_data_v / rx_udp_data / rx_udp_last  output  1 / OCT / 1  payload beat, its byte, and final-beat flag.
REQ-014 rx_udp_err  output  1  one-cycle pulse on a malformed or truncated segment.
REQ-015 rx_udp_drop  output  1  one-cycle pulse when the header matches no enabled port.

Function
REQ-016 States SHALL be: HDR, PAYLOAD, DRAIN; a 16-bit byte counter cnt.
REQ-017 Whenever rx_data_v=0, the block SHALL go to HDR with cnt=0 and force rx_udp_data_v=0 and rx_udp_last=0; this takes priority over all other transitions.
REQ-018 HDR: bytes 0-1 shift into src, 2-3 into dst, 4-5 into len, 6-7 into checksum; cnt increments per valid byte.
REQ-019 On header byte 7, the block SHALL register rx_src_port, rx_dst_port, rx_pay_len and rx_hit, and pulse rx_hdr_v in the following cycle.
REQ-020 Match: channel i hits when port_en[i] and port_tbl[i] equals dst; with multiple hits, the lowest index wins (rx_hit is strictly one-hot or zero).
REQ-021 If len < 8, the block SHALL pulse rx_udp_err, leave rx_hit at 0, and go to DRAIN.
REQ-022 If no channel hits, the block SHALL pulse rx_udp_drop and go to DRAIN.
REQ-023 If len = 8 with a hit, the block SHALL produce no payload beats and go to DRAIN.
REQ-024 Otherwise the block SHALL go to PAYLOAD with cnt=0.
REQ-025 PAYLOAD: each valid input byte SHALL appear on rx_udp_data with rx_udp_data_v=1 exactly one cycle later; cnt increments per byte.
REQ-026 rx_udp_last SHALL assert together with the beat where cnt = rx_pay_len-1; the block then goes to DRAIN.
REQ-027 DRAIN: input bytes (IP padding, excess) are ignored and outputs stay idle until rx_data_v falls.
REQ-028 Truncation: if rx_data_v falls in PAYLOAD before the last byte, the block SHALL pulse rx_udp_err one cycle after the fall and never assert rx_udp_last for that frame.
REQ-029 The checksum is captured but not verified; the checksum field is not an output.
REQ-030 Back-to-back frames separated by one idle cycle SHALL be parsed with no loss.

Reset
REQ-031 On rst, the block SHALL enter state HDR with cnt=0, and set every output register to 0 (ports, length, rx_hit, data, all valids and pulses).
REQ-032 Reset asserted mid-frame SHALL abort the frame with no err or drop pulse; after release, parsing restarts at the next rising rx_data_v.

Structure
REQ-033 Package rx_udp_pkg SHALL hold the state encodings, UDP_HDR_LEN=8, and the header field byte offsets.
REQ-034 Sub-module rx_udp_port_match (combinational compare plus lowest-index priority encoder, parametrised by N_PORT) SHALL produce the one-hot hit.

Verification
REQ-035 tbl[1]=0x1234 enabled, frame dst=0x1234, len=0x000C, payload AA BB CC DD -> rx_hit=0010, 4 beats AA..DD, last on DD, no err.
REQ-036 dst=0x9999 (no match) -> rx_udp_drop pulse, zero data beats, rx_hit=0.
REQ-037 len=0x000A but rx_data_v drops after 1 payload byte -> 1 beat, no last, rx_udp_err pulse.
REQ-038 len=0x000C with 6 trailing pad bytes -> 4 beats then idle through pad bytes; tbl[0]=tbl[2]=dst both enabled -> rx_hit=0001.
REQ-039 len=0x0005 -> rx_udp_err pulse, no beats; len=0x0008 with a hit -> rx_hdr_v pulse, no beats.
REQ-040 rst pulse mid-payload, then a clean frame -> outputs 0 during reset, second frame received intact.
